ifetch_buffer: RTL and testbench

- Sits between the instruction fetch stage (PC generator) and decode.
- Turns the fetch PC into instruction-memory bus requests and tracks in-flight requests.
- Queues returned instructions with their PC and exception bits in a small FIFO, and presents them to decode over a valid/ready handshake.
- Drives stall back to the fetch stage and drops stale responses on a pipeline flush.

---
 rtl/ifb_pkg.sv | 30 +++
 rtl/ifb_fifo.sv | 59 +++++
 rtl/ifetch_buffer.sv | 145 ++++++++++++++
 tb/tb_ifetch_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifb_pkg.sv
// Shared constants, entry layout and pack/unpack helpers for the instruction
// fetch buffer.
package ifb_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam int unsigned EXC_MISALIGN = 0;
    localparam int unsigned EXC_FAULT    = 1;
    localparam int unsigned ENTRY_W      = 32 + 32 + 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  exc;
    } ifb_entry_t;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [31:0] instr,
                                                      input logic [31:0] pc,
                                                      input logic [1:0]  exc);
        ifb_entry_t e;
        e.instr = instr;
        e.pc    = pc;
        e.exc   = exc;
        return e;
    endfunction

    function automatic ifb_entry_t unpack_entry(input logic [ENTRY_W-1:0] bits);
        return ifb_entry_t'(bits);
    endfunction

endpackage

// File: rtl/ifb_fifo.sv
// Synchronous FIFO with clear; pointers carry one extra wrap bit, so DEPTH
// must be a power of two and at least 2.
module ifb_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '{default: '0};
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !clear) begin
            assert (!(push && full && !do_pop));
        end
    end

endmodule

// File: rtl/ifetch_buffer.sv
// Fetch request/response buffer between the PC generator and decode.
// Optional IFB_BYPASS_EN: forward a response straight to decode when the FIFO is empty.
module ifetch_buffer
    import ifb_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned MAX_OUT   = 2,
    parameter logic [31:0] NOP_INSTR = ifb_pkg::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_i,
    input  logic        mis_addr_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [1:0]  id_exc_o
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned PCQ_DEPTH = (MAX_OUT < 2) ? 2 : MAX_OUT;
    localparam int unsigned PW        = $clog2(PCQ_DEPTH);

    logic [AW:0]          fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic [ENTRY_W-1:0]   fifo_wdata;
    logic [ENTRY_W-1:0]   fifo_rdata;
    logic [PW:0]          outstanding;
    logic                 pcq_full;
    logic                 pcq_empty;
    logic [31:0]          rsp_pc;
    logic [PW:0]          squash_q;
    logic [PW:0]          squash_d;
    logic [31:0]          occupancy;
    logic                 credit_ok;
    logic                 granted;
    logic                 mis_write;
    logic                 rsp_accept;
    logic                 bypass;
    logic [1:0]           rsp_exc;
    logic [1:0]           mis_exc;
    ifb_entry_t           head;
    logic                 unused_flags;

    assign unused_flags = ^{fifo_full, pcq_full, pcq_empty};

    assign occupancy   = 32'(fifo_count) + 32'(outstanding);
    assign credit_ok   = occupancy < DEPTH;
    assign imem_req_o  = rst_ni && !flush_i && !mis_addr_i && credit_ok
                         && (32'(outstanding) < MAX_OUT);
    assign imem_addr_o = pc_i;
    assign granted     = imem_req_o && imem_gnt_i;
    assign mis_write   = rst_ni && !flush_i && mis_addr_i && (outstanding == '0) && credit_ok;
    assign stall_o     = rst_ni && !flush_i && !(granted || mis_write);
    assign rsp_accept  = imem_rvalid_i && (squash_q == '0) && !flush_i;

`ifdef IFB_BYPASS_EN
    assign bypass = rst_ni && fifo_empty && rsp_accept;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        rsp_exc               = '0;
        rsp_exc[EXC_FAULT]    = imem_err_i;
        mis_exc               = '0;
        mis_exc[EXC_MISALIGN] = 1'b1;
        fifo_wdata = mis_write ? pack_entry(NOP_INSTR, pc_i, mis_exc)
                               : pack_entry(imem_rdata_i, rsp_pc, rsp_exc);
    end

    assign fifo_push = (rsp_accept && !(bypass && id_ready_i)) || mis_write;
    assign fifo_pop  = !fifo_empty && id_ready_i;
    assign head      = unpack_entry(fifo_rdata);

    assign id_valid_o = rst_ni && (!fifo_empty || bypass);
    assign id_instr_o = bypass ? imem_rdata_i : head.instr;
    assign id_pc_o    = bypass ? rsp_pc       : head.pc;
    assign id_exc_o   = bypass ? rsp_exc      : head.exc;

    // A flush marks every request still in flight as stale, which already
    // covers any squash count left over from an earlier flush.
    always_comb begin
        squash_d = squash_q;
        if (imem_rvalid_i && (squash_q != '0)) begin
            squash_d = squash_q - (PW+1)'(1);
        end
        if (flush_i) begin
            squash_d = outstanding - (PW+1)'(imem_rvalid_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            squash_q <= '0;
        end else begin
            squash_q <= squash_d;
        end
    end

    ifb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (flush_i),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    ifb_fifo #(
        .WIDTH (32),
        .DEPTH (PCQ_DEPTH)
    ) u_pc_queue (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .push  (granted),
        .pop   (imem_rvalid_i),
        .clear (1'b0),
        .wdata (pc_i),
        .rdata (rsp_pc),
        .full  (pcq_full),
        .empty (pcq_empty),
        .count (outstanding)
    );

endmodule

// File: tb/tb_ifetch_buffer.sv
module tb_ifetch_buffer;

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned MAX_OUT = 2;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] pc_i;
  logic        mis_addr_i;
  logic        flush_i;
  logic        stall_o;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        imem_err_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic [1:0]  id_exc_o;

  ifetch_buffer #(
    .DEPTH     (DEPTH),
    .MAX_OUT   (MAX_OUT),
    .NOP_INSTR (NOP)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .pc_i          (pc_i),
    .mis_addr_i    (mis_addr_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .imem_err_i    (imem_err_i),
    .id_valid_o    (id_valid_o),
    .id_ready_i    (id_ready_i),
    .id_instr_o    (id_instr_o),
    .id_pc_o       (id_pc_o),
    .id_exc_o      (id_exc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  exc;
  } ent_t;

  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } req_t;

  ent_t fq[$];
  req_t oq[$];

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] pc;
  logic [31:0] flush_target;
  bit          mis, flush, gnt, rv_want, ready, err_want;

  task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_fail++;
    $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cycle();
    bit          exp_req, granted, mis_wr, exp_stall, rv, exp_valid;
    int unsigned occ;
    req_t        o;
    pc_i          = pc;
    mis_addr_i    = mis;
    flush_i       = flush;
    imem_gnt_i    = gnt;
    id_ready_i    = ready;
    rv            = rv_want && (oq.size() > 0);
    imem_rvalid_i = rv;
    imem_rdata_i  = $urandom();
    imem_err_i    = err_want;
    #1;
    occ       = fq.size() + oq.size();
    exp_req   = !flush && !mis && (occ < DEPTH) && (oq.size() < MAX_OUT);
    granted   = exp_req && gnt;
    mis_wr    = !flush && mis && (oq.size() == 0) && (occ < DEPTH);
    exp_stall = !flush && !(granted || mis_wr);
    exp_valid = (fq.size() > 0);
    n_assert++;
    if (imem_req_o !== exp_req) fail("imem_req", imem_req_o, exp_req);
    n_assert++;
    if (imem_addr_o !== pc) fail("imem_addr", imem_addr_o, pc);
    n_assert++;
    if (stall_o !== exp_stall) fail("stall", stall_o, exp_stall);
    n_assert++;
    if (id_valid_o !== exp_valid) fail("id_valid", id_valid_o, exp_valid);
    if (fq.size() > 0) begin
      n_assert++;
      if (id_instr_o !== fq[0].instr) fail("id_instr", id_instr_o, fq[0].instr);
      n_assert++;
      if (id_pc_o !== fq[0].pc) fail("id_pc", id_pc_o, fq[0].pc);
      n_assert++;
      if (id_exc_o !== fq[0].exc) fail("id_exc", id_exc_o, fq[0].exc);
    end
    if (fq.size() > 0 && ready) void'(fq.pop_front());
    if (rv) begin
      o = oq.pop_front();
      if (!o.stale && !flush)
        fq.push_back('{instr: imem_rdata_i, pc: o.pc, exc: {imem_err_i, 1'b0}});
    end
    if (mis_wr) fq.push_back('{instr: NOP, pc: pc, exc: 2'b01});
    if (granted) oq.push_back('{pc: pc, stale: 1'b0});
    if (flush) begin
      fq.delete();
      foreach (oq[i]) oq[i].stale = 1'b1;
    end
    if (flush) pc = flush_target;
    else if (!exp_stall) pc = pc + 32'd4;
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int unsigned left;
    mis = 0; flush = 0; gnt = 0; rv_want = 1; ready = 1; err_want = 0;
    for (int unsigned i = 0; i < 16 && (fq.size() > 0 || oq.size() > 0); i++) cycle();
    left = fq.size() + oq.size();
    n_assert++;
    if (left != 0) fail("drain_empty", left, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    int unsigned fill;
    rst_ni = 1'b0;
    pc = 32'h0; flush_target = 32'h0;
    mis = 0; flush = 0; gnt = 0; rv_want = 0; ready = 0; err_want = 0;
    pc_i = '0; mis_addr_i = 0; flush_i = 0; imem_gnt_i = 0;
    imem_rvalid_i = 0; imem_rdata_i = '0; imem_err_i = 0; id_ready_i = 0;
    #3;
    n_assert++;
    if (id_valid_o !== 1'b0) fail("rst_id_valid", id_valid_o, 0);
    n_assert++;
    if (id_instr_o !== 32'h0) fail("rst_id_instr", id_instr_o, 0);
    n_assert++;
    if (id_pc_o !== 32'h0) fail("rst_id_pc", id_pc_o, 0);
    n_assert++;
    if (id_exc_o !== 2'b00) fail("rst_id_exc", id_exc_o, 0);
    n_assert++;
    if (imem_req_o !== 1'b0) fail("rst_req", imem_req_o, 0);
    n_assert++;
    if (stall_o !== 1'b0) fail("rst_stall", stall_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    gnt = 1; rv_want = 1; ready = 1;
    for (int unsigned i = 0; i < 12; i++) cycle();

    ready = 0;
    for (int unsigned i = 0; i < 6; i++) cycle();
    n_assert++;
    if (fq.size() > DEPTH) fail("bp_fifo_bound", fq.size(), DEPTH);
    ready = 1;
    for (int unsigned i = 0; i < 8; i++) cycle();
    drain();

    pc = 32'h10; gnt = 1; rv_want = 0; ready = 1;
    cycle();
    cycle();
    flush = 1; flush_target = 32'h100;
    cycle();
    flush = 0; rv_want = 1;
    seen = 0;
    for (int unsigned i = 0; i < 10 && !seen; i++) begin
      cycle();
      if (id_valid_o) begin
        seen = 1;
        n_assert++;
        if (id_pc_o !== 32'h100) fail("flush_first_pc", id_pc_o, 32'h100);
      end
    end
    n_assert++;
    if (seen !== 1'b1) fail("flush_seen", seen, 1);
    drain();

    pc = 32'h102; mis = 1; gnt = 1; ready = 0;
    cycle();
    n_assert++;
    if (id_valid_o !== 1'b1) fail("mis_valid", id_valid_o, 1);
    n_assert++;
    if (id_pc_o !== 32'h102) fail("mis_pc", id_pc_o, 32'h102);
    n_assert++;
    if (id_instr_o !== 32'h0000_0013) fail("mis_instr", id_instr_o, 32'h13);
    n_assert++;
    if (id_exc_o !== 2'b01) fail("mis_exc", id_exc_o, 1);
    mis = 0; pc = 32'h108; ready = 1;
    cycle();
    drain();

    pc = 32'h20; gnt = 1; rv_want = 0; ready = 0;
    cycle();
    gnt = 0; rv_want = 1; err_want = 1;
    cycle();
    err_want = 0;
    n_assert++;
    if (id_valid_o !== 1'b1) fail("fault_valid", id_valid_o, 1);
    n_assert++;
    if (id_pc_o !== 32'h20) fail("fault_pc", id_pc_o, 32'h20);
    n_assert++;
    if (id_exc_o !== 2'b10) fail("fault_exc", id_exc_o, 2);
    drain();

    pc = 32'h40; gnt = 1; rv_want = 1; ready = 0;
    for (int unsigned i = 0; i < 10 && fq.size() < 2; i++) cycle();
    fill = fq.size();
    n_assert++;
    if (fill != 2) fail("ar_fill", fill, 2);
    #1;
    rst_ni = 1'b0;
    #1;
    n_assert++;
    if (id_valid_o !== 1'b0) fail("ar_id_valid", id_valid_o, 0);
    n_assert++;
    if (imem_req_o !== 1'b0) fail("ar_req", imem_req_o, 0);
    n_assert++;
    if (stall_o !== 1'b0) fail("ar_stall", stall_o, 0);
    imem_rvalid_i = 0;
    fq.delete();
    oq.delete();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    pc = 32'h80;

    for (int unsigned i = 0; i < 400; i++) begin
      gnt          = ($urandom_range(0, 3) != 0);
      rv_want      = ($urandom_range(0, 2) != 0);
      ready        = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      mis          = ($urandom_range(0, 11) == 0);
      err_want     = ($urandom_range(0, 7) == 0);
      flush_target = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
